// File: rtl/udma_filter_rx_dataout_3d_if.sv
`default_nettype none
// ============================================================================
// Module   : udma_filter_rx_dataout_3d_if
// Purpose  : L2 RX channel and input stream bundle of the filter data-out block
// Revision : 1.0 - initial release
// ============================================================================
interface udma_filter_rx_dataout_3d_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int L2_AWIDTH_NOAL = 15
);
    logic [L2_AWIDTH_NOAL-1:0] rx_ch_addr_o;
    logic [1:0]                rx_ch_datasize_o;
    logic                      rx_ch_valid_o;
    logic [DATA_WIDTH-1:0]     rx_ch_data_o;
    logic                      rx_ch_ready_i;
    logic [DATA_WIDTH-1:0]     stream_data_i;
    logic                      stream_valid_i;
    logic                      stream_ready_o;

    modport master (
        output rx_ch_addr_o,
        output rx_ch_datasize_o,
        output rx_ch_valid_o,
        output rx_ch_data_o,
        input  rx_ch_ready_i,
        input  stream_data_i,
        input  stream_valid_i,
        output stream_ready_o
    );

    modport slave (
        input  rx_ch_addr_o,
        input  rx_ch_datasize_o,
        input  rx_ch_valid_o,
        input  rx_ch_data_o,
        output rx_ch_ready_i,
        output stream_data_i,
        output stream_valid_i,
        input  stream_ready_o
    );
endinterface
`default_nettype wire

// File: rtl/udma_filter_rx_dataout_3d.sv
`default_nettype none
// ============================================================================
// Module   : udma_filter_rx_dataout_3d
// Purpose  : Buffers a data stream and writes it to L2 with 1D/2D/3D addressing
// Revision : 1.0 - initial release
// ============================================================================
module udma_filter_rx_dataout_3d #(
    parameter int DATA_WIDTH     = 32,
    parameter int L2_AWIDTH_NOAL = 15,
    parameter int BUFFER_DEPTH   = 4,
    parameter int TRANS_SIZE     = 16
) (
    input  logic                              clk_i,
    input  logic                              resetn_i,
    udma_filter_rx_dataout_3d_if.master       bus,
    input  logic                              cmd_start_i,
    input  logic                              cmd_abort_i,
    output logic                              cmd_done_o,
    output logic                              busy_o,
    output logic [$clog2(BUFFER_DEPTH):0]     fifo_elements_o,
    input  logic [L2_AWIDTH_NOAL-1:0]         cfg_start_addr_i,
    input  logic [1:0]                        cfg_datasize_i,
    input  logic [1:0]                        cfg_mode_i,
    input  logic [TRANS_SIZE-1:0]             cfg_len0_i,
    input  logic [TRANS_SIZE-1:0]             cfg_len1_i,
    input  logic [TRANS_SIZE-1:0]             cfg_len2_i,
    input  logic [TRANS_SIZE-1:0]             cfg_len3_i,
    input  logic [TRANS_SIZE-1:0]             cfg_len4_i
);

    localparam int C_PTR_W = $clog2(BUFFER_DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;
    localparam int C_AW    = L2_AWIDTH_NOAL;

    localparam logic [1:0] C_MODE_LINEAR = 2'd0;
    localparam logic [1:0] C_MODE_ROW    = 2'd1;
    localparam logic [1:0] C_MODE_COL    = 2'd2;
    localparam logic [1:0] C_MODE_3D     = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RUNNING = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
    logic [C_PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [C_PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [C_CNT_W-1:0]    count_q, count_d;
    logic                  ready_en_q, ready_en_d;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_valid;

    state_t state_q, state_d;

    assign w_full  = (count_q == C_CNT_W'(BUFFER_DEPTH));
    assign w_empty = (count_q == '0);
    assign w_valid = !w_empty && (state_q == ST_RUNNING);
    assign w_push  = bus.stream_valid_i && bus.stream_ready_o;
    assign w_pop   = w_valid && bus.rx_ch_ready_i;

    // ready_en holds stream_ready low until the first edge after reset release
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ready_en_d = 1'b1;
        if (cmd_abort_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + C_CNT_W'(w_push) - C_CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_en_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_en_q <= ready_en_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= bus.stream_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Transfer control and address generation
    // ------------------------------------------------------------------
    logic [1:0]            mode_q, mode_d;
    logic [1:0]            ds_q, ds_d;
    logic [TRANS_SIZE-1:0] len0_q, len0_d;
    logic [TRANS_SIZE-1:0] len1_q, len1_d;
    logic [TRANS_SIZE-1:0] len2_q, len2_d;
    logic [TRANS_SIZE-1:0] len3_q, len3_d;
    logic [TRANS_SIZE-1:0] len4_q, len4_d;
    logic [C_AW-1:0]       ptr_q, ptr_d;
    logic [C_AW-1:0]       line_q, line_d;
    logic [C_AW-1:0]       plane_q, plane_d;
    logic [TRANS_SIZE-1:0] w_cnt_q, w_cnt_d;
    logic [TRANS_SIZE-1:0] l_cnt_q, l_cnt_d;
    logic [TRANS_SIZE-1:0] p_cnt_q, p_cnt_d;
    logic                  done_q, done_d;

    logic [C_AW-1:0] w_inc;
    logic [C_AW-1:0] w_ptr_inc;
    logic [C_AW-1:0] w_ptr_stride;
    logic [C_AW-1:0] w_line_inc;
    logic [C_AW-1:0] w_line_stride;
    logic [C_AW-1:0] w_plane_stride;
    logic            w_w_last;
    logic            w_l_last;
    logic            w_p_last;
    logic            w_last;

    always_comb begin
        case (ds_q)
            2'd0:    w_inc = C_AW'(1);
            2'd1:    w_inc = C_AW'(2);
            2'd2:    w_inc = C_AW'(4);
            default: w_inc = '0;
        endcase
    end

    // Strides are truncated/zero-extended to the address width; sums wrap
    assign w_ptr_inc      = ptr_q + w_inc;
    assign w_ptr_stride   = ptr_q + C_AW'(len2_q);
    assign w_line_inc     = line_q + w_inc;
    assign w_line_stride  = line_q + C_AW'(len2_q);
    assign w_plane_stride = plane_q + C_AW'(len4_q);

    assign w_w_last = (w_cnt_q == len0_q);
    assign w_l_last = (l_cnt_q == len1_q);
    assign w_p_last = (p_cnt_q == len3_q);

    always_comb begin
        case (mode_q)
            C_MODE_LINEAR: w_last = w_w_last;
            C_MODE_ROW,
            C_MODE_COL:    w_last = w_w_last && w_l_last;
            default:       w_last = w_w_last && w_l_last && w_p_last;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        ds_d    = ds_q;
        len0_d  = len0_q;
        len1_d  = len1_q;
        len2_d  = len2_q;
        len3_d  = len3_q;
        len4_d  = len4_q;
        ptr_d   = ptr_q;
        line_d  = line_q;
        plane_d = plane_q;
        w_cnt_d = w_cnt_q;
        l_cnt_d = l_cnt_q;
        p_cnt_d = p_cnt_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_start_i && !cmd_abort_i) begin
                    state_d = ST_RUNNING;
                    mode_d  = cfg_mode_i;
                    ds_d    = cfg_datasize_i;
                    len0_d  = cfg_len0_i;
                    len1_d  = cfg_len1_i;
                    len2_d  = cfg_len2_i;
                    len3_d  = cfg_len3_i;
                    len4_d  = cfg_len4_i;
                    ptr_d   = cfg_start_addr_i;
                    line_d  = cfg_start_addr_i;
                    plane_d = cfg_start_addr_i;
                    w_cnt_d = '0;
                    l_cnt_d = '0;
                    p_cnt_d = '0;
                end
            end

            ST_RUNNING: begin
                if (cmd_abort_i) begin
                    state_d = ST_IDLE;
                    w_cnt_d = '0;
                    l_cnt_d = '0;
                    p_cnt_d = '0;
                end else if (w_pop) begin
                    if (w_last) begin
                        state_d = ST_IDLE;
                        w_cnt_d = '0;
                        l_cnt_d = '0;
                        p_cnt_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        case (mode_q)
                            C_MODE_LINEAR: begin
                                w_cnt_d = w_cnt_q + 1'b1;
                                ptr_d   = w_ptr_inc;
                            end
                            C_MODE_ROW: begin
                                if (w_w_last) begin
                                    w_cnt_d = '0;
                                    l_cnt_d = l_cnt_q + 1'b1;
                                    line_d  = w_line_stride;
                                    ptr_d   = w_line_stride;
                                end else begin
                                    w_cnt_d = w_cnt_q + 1'b1;
                                    ptr_d   = w_ptr_inc;
                                end
                            end
                            // Column mode walks down the lines first, then steps across
                            C_MODE_COL: begin
                                if (w_l_last) begin
                                    l_cnt_d = '0;
                                    w_cnt_d = w_cnt_q + 1'b1;
                                    line_d  = w_line_inc;
                                    ptr_d   = w_line_inc;
                                end else begin
                                    l_cnt_d = l_cnt_q + 1'b1;
                                    ptr_d   = w_ptr_stride;
                                end
                            end
                            default: begin
                                if (w_w_last && w_l_last) begin
                                    w_cnt_d = '0;
                                    l_cnt_d = '0;
                                    p_cnt_d = p_cnt_q + 1'b1;
                                    plane_d = w_plane_stride;
                                    line_d  = w_plane_stride;
                                    ptr_d   = w_plane_stride;
                                end else if (w_w_last) begin
                                    w_cnt_d = '0;
                                    l_cnt_d = l_cnt_q + 1'b1;
                                    line_d  = w_line_stride;
                                    ptr_d   = w_line_stride;
                                end else begin
                                    w_cnt_d = w_cnt_q + 1'b1;
                                    ptr_d   = w_ptr_inc;
                                end
                            end
                        endcase
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= ST_IDLE;
            mode_q  <= C_MODE_LINEAR;
            ds_q    <= '0;
            len0_q  <= '0;
            len1_q  <= '0;
            len2_q  <= '0;
            len3_q  <= '0;
            len4_q  <= '0;
            ptr_q   <= '0;
            line_q  <= '0;
            plane_q <= '0;
            w_cnt_q <= '0;
            l_cnt_q <= '0;
            p_cnt_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            ds_q    <= ds_d;
            len0_q  <= len0_d;
            len1_q  <= len1_d;
            len2_q  <= len2_d;
            len3_q  <= len3_d;
            len4_q  <= len4_d;
            ptr_q   <= ptr_d;
            line_q  <= line_d;
            plane_q <= plane_d;
            w_cnt_q <= w_cnt_d;
            l_cnt_q <= l_cnt_d;
            p_cnt_q <= p_cnt_d;
            done_q  <= done_d;
        end
    end

    assign bus.rx_ch_addr_o     = ptr_q;
    assign bus.rx_ch_datasize_o = ds_q;
    assign bus.rx_ch_valid_o    = w_valid;
    assign bus.rx_ch_data_o     = mem_q[rd_ptr_q];
    assign bus.stream_ready_o   = ready_en_q && !w_full;
    assign cmd_done_o           = done_q;
    assign busy_o               = (state_q == ST_RUNNING);
    assign fifo_elements_o      = count_q;

endmodule
`default_nettype wire

// File: tb/tb_udma_filter_rx_dataout_3d.sv
`default_nettype none
// ============================================================================
// Module   : tb_udma_filter_rx_dataout_3d
// Purpose  : Directed self-checking bench for udma_filter_rx_dataout_3d
// Revision : 1.0 - initial release
// ============================================================================
module tb_udma_filter_rx_dataout_3d;

    localparam int DW = 32;
    localparam int AW = 15;
    localparam int BD = 4;
    localparam int TS = 16;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic          cmd_start, cmd_abort, cmd_done, busy;
    logic [2:0]    fifo_el;
    logic [AW-1:0] cfg_addr;
    logic [1:0]    cfg_ds, cfg_mode;
    logic [TS-1:0] len0, len1, len2, len3, len4;

    udma_filter_rx_dataout_3d_if #(.DATA_WIDTH(DW), .L2_AWIDTH_NOAL(AW)) bus ();

    udma_filter_rx_dataout_3d #(
        .DATA_WIDTH(DW), .L2_AWIDTH_NOAL(AW), .BUFFER_DEPTH(BD), .TRANS_SIZE(TS)
    ) dut (
        .clk_i(clk), .resetn_i(resetn), .bus(bus.master),
        .cmd_start_i(cmd_start), .cmd_abort_i(cmd_abort), .cmd_done_o(cmd_done),
        .busy_o(busy), .fifo_elements_o(fifo_el), .cfg_start_addr_i(cfg_addr),
        .cfg_datasize_i(cfg_ds), .cfg_mode_i(cfg_mode), .cfg_len0_i(len0),
        .cfg_len1_i(len1), .cfg_len2_i(len2), .cfg_len3_i(len3), .cfg_len4_i(len4)
    );

    int checks = 0;
    int errors = 0;

    // Monitor state, written only by the monitor process
    int            cyc = 0, beat_n = 0, done_n = 0, done_cyc = 0, hold_err = 0, full_err = 0;
    logic [AW-1:0] addr_log [64];
    logic [DW-1:0] data_log [64];
    int            beat_cyc [64];
    bit            push_seen = 1'b0, stall_prev = 1'b0;
    logic [AW-1:0] stall_addr = '0;

    // Source state: src_sent owned by the driver, src_limit/rand_valid by tests
    int src_sent = 0, src_limit = 0;
    bit rand_valid = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        push_seen = (bus.stream_valid_i === 1'b1) && (bus.stream_ready_o === 1'b1);
        if (bus.rx_ch_valid_o === 1'b1 && bus.rx_ch_ready_i === 1'b1 && beat_n < 64) begin
            addr_log[beat_n] = bus.rx_ch_addr_o;
            data_log[beat_n] = bus.rx_ch_data_o;
            beat_cyc[beat_n] = cyc;
            beat_n = beat_n + 1;
        end
        if (cmd_done === 1'b1) begin
            done_n   = done_n + 1;
            done_cyc = cyc;
        end
        if (stall_prev && bus.rx_ch_valid_o === 1'b1 && bus.rx_ch_addr_o !== stall_addr)
            hold_err = hold_err + 1;
        stall_prev = (bus.rx_ch_valid_o === 1'b1) && (bus.rx_ch_ready_i !== 1'b1);
        stall_addr = bus.rx_ch_addr_o;
        if (fifo_el == 3'(BD) && bus.stream_ready_o === 1'b1)
            full_err = full_err + 1;
    end

    // Stream source: item k carries data D000_0000 + k
    initial begin
        bus.stream_valid_i = 1'b0;
        bus.stream_data_i  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (push_seen) src_sent = src_sent + 1;
            if (src_sent < src_limit && (!rand_valid || $urandom_range(0, 1) == 1)) begin
                bus.stream_valid_i = 1'b1;
                bus.stream_data_i  = 32'hD000_0000 + 32'(src_sent);
            end else begin
                bus.stream_valid_i = 1'b0;
            end
        end
    end

    task automatic start_xfer(input logic [1:0] mode, input logic [1:0] ds, input logic [AW-1:0] addr,
                              input logic [TS-1:0] l0, l1, l2, l3, l4);
        @(posedge clk); #1;
        cfg_mode = mode; cfg_ds = ds; cfg_addr = addr;
        len0 = l0; len1 = l1; len2 = l2; len3 = l3; len4 = l4;
        cmd_start = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        cfg_mode = 2'd3; cfg_ds = 2'd0; cfg_addr = 15'h7FFF;
        len0 = '1; len1 = '1; len2 = '1; len3 = '1; len4 = '1;
    endtask

    task automatic wait_beats(input int target, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #2;
            if (beat_n >= target) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0; cmd_start = 1'b0; cmd_abort = 1'b0;
        bus.rx_ch_ready_i = 1'b0;
        cfg_addr = '0; cfg_ds = '0; cfg_mode = '0;
        len0 = '0; len1 = '0; len2 = '0; len3 = '0; len4 = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.rx_ch_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.rx_ch_valid_o); end
        checks++; if (cmd_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", cmd_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (bus.stream_ready_o !== 1'b0) begin errors++; $display("FAIL reset_sready: got %b expected 0", bus.stream_ready_o); end
        checks++; if (fifo_el !== 3'd0) begin errors++; $display("FAIL reset_fifo: got %0d expected 0", fifo_el); end
        checks++; if (bus.rx_ch_addr_o !== 15'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", bus.rx_ch_addr_o); end
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.stream_ready_o !== 1'b1) begin errors++; $display("FAIL release_sready: got %b expected 1", bus.stream_ready_o); end
    endtask

    task automatic test_linear;
        int first, b0, d0;
        bit to;
        logic [AW-1:0] exp [4];
        exp[0] = 15'h100; exp[1] = 15'h104; exp[2] = 15'h108; exp[3] = 15'h10C;
        first = src_limit; src_limit = src_limit + 4;
        bus.rx_ch_ready_i = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (bus.rx_ch_valid_o !== 1'b0) begin errors++; $display("FAIL idle_no_emit: got %b expected 0", bus.rx_ch_valid_o); end
        b0 = beat_n; d0 = done_n;
        start_xfer(2'd0, 2'd2, 15'h100, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0);
        checks++; if (bus.rx_ch_datasize_o !== 2'd2) begin errors++; $display("FAIL lin_datasize: got %0d expected 2", bus.rx_ch_datasize_o); end
        wait_beats(b0 + 4, to);
        checks++; if (to) begin errors++; $display("FAIL lin_timeout: got %0d beats expected 4", beat_n - b0); end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (addr_log[b0+k] !== exp[k]) begin errors++; $display("FAIL lin_addr%0d: got %h expected %h", k, addr_log[b0+k], exp[k]); end
            checks++; if (data_log[b0+k] !== 32'hD000_0000 + 32'(first + k)) begin errors++; $display("FAIL lin_data%0d: got %h expected %h", k, data_log[b0+k], 32'hD000_0000 + 32'(first + k)); end
        end
        checks++; if (done_n - d0 != 1) begin errors++; $display("FAIL lin_done_count: got %0d expected 1", done_n - d0); end
        checks++; if (done_cyc != beat_cyc[b0+3] + 1) begin errors++; $display("FAIL lin_done_timing: got %0d expected %0d", done_cyc, beat_cyc[b0+3] + 1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lin_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_2d_row;
        int first, b0, d0;
        bit to;
        logic [AW-1:0] exp [6];
        exp[0] = 15'h00; exp[1] = 15'h01; exp[2] = 15'h10; exp[3] = 15'h11; exp[4] = 15'h20; exp[5] = 15'h21;
        first = src_limit; src_limit = src_limit + 6;
        b0 = beat_n; d0 = done_n;
        start_xfer(2'd1, 2'd0, 15'h0, 16'd1, 16'd2, 16'h10, 16'd0, 16'd0);
        wait_beats(b0 + 6, to);
        checks++; if (to) begin errors++; $display("FAIL row_timeout: got %0d beats expected 6", beat_n - b0); end
        repeat (3) @(posedge clk);
        for (int k = 0; k < 6; k++) begin
            checks++; if (addr_log[b0+k] !== exp[k]) begin errors++; $display("FAIL row_addr%0d: got %h expected %h", k, addr_log[b0+k], exp[k]); end
        end
        checks++; if (data_log[b0+5] !== 32'hD000_0000 + 32'(first + 5)) begin errors++; $display("FAIL row_data5: got %h expected %h", data_log[b0+5], 32'hD000_0000 + 32'(first + 5)); end
        checks++; if (done_n - d0 != 1) begin errors++; $display("FAIL row_done_count: got %0d expected 1", done_n - d0); end
    endtask

    task automatic test_2d_col;
        int b0, d0;
        bit to;
        logic [AW-1:0] exp [4];
        exp[0] = 15'h0; exp[1] = 15'h8; exp[2] = 15'h2; exp[3] = 15'hA;
        src_limit = src_limit + 4;
        b0 = beat_n; d0 = done_n;
        start_xfer(2'd2, 2'd1, 15'h0, 16'd1, 16'd1, 16'h8, 16'd0, 16'd0);
        wait_beats(b0 + 4, to);
        checks++; if (to) begin errors++; $display("FAIL col_timeout: got %0d beats expected 4", beat_n - b0); end
        repeat (3) @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++; if (addr_log[b0+k] !== exp[k]) begin errors++; $display("FAIL col_addr%0d: got %h expected %h", k, addr_log[b0+k], exp[k]); end
        end
        checks++; if (done_n - d0 != 1) begin errors++; $display("FAIL col_done_count: got %0d expected 1", done_n - d0); end
    endtask

    task automatic test_3d;
        int b0, d0;
        bit to;
        logic [AW-1:0] exp [8];
        exp[0] = 15'h000; exp[1] = 15'h004; exp[2] = 15'h020; exp[3] = 15'h024;
        exp[4] = 15'h100; exp[5] = 15'h104; exp[6] = 15'h120; exp[7] = 15'h124;
        src_limit = src_limit + 8;
        b0 = beat_n; d0 = done_n;
        start_xfer(2'd3, 2'd2, 15'h0, 16'd1, 16'd1, 16'h20, 16'd1, 16'h100);
        wait_beats(b0 + 8, to);
        checks++; if (to) begin errors++; $display("FAIL 3d_timeout: got %0d beats expected 8", beat_n - b0); end
        repeat (4) @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            checks++; if (addr_log[b0+k] !== exp[k]) begin errors++; $display("FAIL 3d_addr%0d: got %h expected %h", k, addr_log[b0+k], exp[k]); end
        end
        checks++; if (done_n - d0 != 1) begin errors++; $display("FAIL 3d_done_count: got %0d expected 1", done_n - d0); end
        checks++; if (beat_n - b0 != 8) begin errors++; $display("FAIL 3d_beat_count: got %0d expected 8", beat_n - b0); end
    endtask

    task automatic test_back_to_back_random;
        int first, b0, d0;
        bit to;
        bus.rx_ch_ready_i = 1'b0;
        rand_valid = 1'b1;
        first = src_limit; src_limit = src_limit + 20;
        repeat (30) @(posedge clk);
        #1;
        checks++; if (fifo_el !== 3'd4) begin errors++; $display("FAIL rnd_fill: got %0d expected 4", fifo_el); end
        checks++; if (bus.stream_ready_o !== 1'b0) begin errors++; $display("FAIL rnd_full_ready: got %b expected 0", bus.stream_ready_o); end
        b0 = beat_n; d0 = done_n;
        start_xfer(2'd0, 2'd2, 15'h40, 16'd19, 16'd0, 16'd0, 16'd0, 16'd0);
        for (int i = 0; i < 600 && beat_n < b0 + 20; i++) begin
            @(posedge clk); #1;
            bus.rx_ch_ready_i = ($urandom_range(0, 1) == 1);
        end
        to = (beat_n < b0 + 20);
        bus.rx_ch_ready_i = 1'b1;
        rand_valid = 1'b0;
        checks++; if (to) begin errors++; $display("FAIL rnd_timeout: got %0d beats expected 20", beat_n - b0); end
        repeat (3) @(posedge clk);
        for (int k = 0; k < 20; k++) begin
            checks++; if (addr_log[b0+k] !== 15'h40 + 15'(4 * k)) begin errors++; $display("FAIL rnd_addr%0d: got %h expected %h", k, addr_log[b0+k], 15'h40 + 15'(4 * k)); end
            checks++; if (data_log[b0+k] !== 32'hD000_0000 + 32'(first + k)) begin errors++; $display("FAIL rnd_data%0d: got %h expected %h", k, data_log[b0+k], 32'hD000_0000 + 32'(first + k)); end
        end
        checks++; if (hold_err != 0) begin errors++; $display("FAIL rnd_addr_hold: got %0d changes expected 0", hold_err); end
        checks++; if (full_err != 0) begin errors++; $display("FAIL rnd_ready_full: got %0d cycles expected 0", full_err); end
        checks++; if (done_n - d0 != 1) begin errors++; $display("FAIL rnd_done_count: got %0d expected 1", done_n - d0); end
    endtask

    task automatic test_abort;
        int first, b0, d0;
        bit to;
        // abort in IDLE flushes and beats a simultaneous start
        bus.rx_ch_ready_i = 1'b0;
        src_limit = src_limit + 2;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (fifo_el !== 3'd2) begin errors++; $display("FAIL idle_abort_pre: got %0d expected 2", fifo_el); end
        cfg_mode = 2'd0; cfg_ds = 2'd2; cfg_addr = 15'h10; len0 = 16'd3;
        cmd_start = 1'b1; cmd_abort = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0; cmd_abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_abort_busy: got %b expected 0", busy); end
        checks++; if (fifo_el !== 3'd0) begin errors++; $display("FAIL idle_abort_flush: got %0d expected 0", fifo_el); end

        first = src_limit; src_limit = src_limit + 4;
        repeat (8) @(posedge clk);
        b0 = beat_n; d0 = done_n;
        start_xfer(2'd0, 2'd2, 15'h300, 16'd7, 16'd0, 16'd0, 16'd0, 16'd0);
        bus.rx_ch_ready_i = 1'b1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_run: got %b expected 1", busy); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.rx_ch_ready_i = 1'b0; cmd_abort = 1'b1;
        @(posedge clk); #1;
        cmd_abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (fifo_el !== 3'd0) begin errors++; $display("FAIL abort_flush: got %0d expected 0", fifo_el); end
        checks++; if (beat_n - b0 != 2) begin errors++; $display("FAIL abort_beats: got %0d expected 2", beat_n - b0); end
        checks++; if (addr_log[b0+1] !== 15'h304) begin errors++; $display("FAIL abort_addr1: got %h expected 304", addr_log[b0+1]); end
        checks++; if (data_log[b0+1] !== 32'hD000_0000 + 32'(first + 1)) begin errors++; $display("FAIL abort_data1: got %h expected %h", data_log[b0+1], 32'hD000_0000 + 32'(first + 1)); end
        repeat (5) @(posedge clk);
        checks++; if (done_n != d0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_n - d0); end

        first = src_limit; src_limit = src_limit + 1;
        bus.rx_ch_ready_i = 1'b1;
        b0 = beat_n;
        start_xfer(2'd0, 2'd2, 15'h200, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        wait_beats(b0 + 1, to);
        checks++; if (to) begin errors++; $display("FAIL post_abort_timeout: got %0d beats expected 1", beat_n - b0); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (addr_log[b0] !== 15'h200) begin errors++; $display("FAIL post_abort_addr: got %h expected 200", addr_log[b0]); end
        checks++; if (data_log[b0] !== 32'hD000_0000 + 32'(first)) begin errors++; $display("FAIL post_abort_data: got %h expected %h", data_log[b0], 32'hD000_0000 + 32'(first)); end
        checks++; if (done_n - d0 != 1) begin errors++; $display("FAIL post_abort_done: got %0d expected 1", done_n - d0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_abort_busy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid;
        int d0;
        bus.rx_ch_ready_i = 1'b0;
        src_limit = src_limit + 4;
        repeat (8) @(posedge clk);
        d0 = done_n;
        start_xfer(2'd0, 2'd2, 15'h500, 16'd7, 16'd0, 16'd0, 16'd0, 16'd0);
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (bus.rx_ch_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", bus.rx_ch_valid_o); end
        checks++; if (fifo_el !== 3'd0) begin errors++; $display("FAIL rstmid_fifo: got %0d expected 0", fifo_el); end
        checks++; if (bus.rx_ch_addr_o !== 15'h0) begin errors++; $display("FAIL rstmid_addr: got %h expected 0", bus.rx_ch_addr_o); end
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (done_n != d0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", done_n - d0); end
        checks++; if (bus.stream_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_sready: got %b expected 1", bus.stream_ready_o); end
    endtask

    initial begin
        test_reset();
        test_linear();
        test_2d_row();
        test_2d_col();
        test_3d();
        test_back_to_back_random();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/udma_filter_rx_dataout_3d.md
UDMA_FILTER_RX_DATAOUT_3D -- requirements
Module: udma_filter_rx_dataout_3d

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of stream and L2 data.
REQ-002 Parameter L2_AWIDTH_NOAL, 15, L2 byte-address width.
REQ-003 Parameter BUFFER_DEPTH, 4, internal FIFO entries, power of two, 2 or more.
REQ-004 Parameter TRANS_SIZE, 16, width of count and stride fields.
REQ-005 Port list, one per line (name, direction, width, meaning):
- clk_i, in, 1, single clock; rising edge.
- resetn_i, in, 1, reset, asynchronous, active-low.
- rx_ch_addr_o, out, L2_AWIDTH_NOAL, L2 byte address of the current beat.
- rx_ch_datasize_o, out, 2, equals the latched datasize.
- rx_ch_valid_o, out, 1, beat valid.
- rx_ch_data_o, out, DATA_WIDTH, beat data.
- rx_ch_ready_i, in, 1, L2 channel accepts the beat.
- cmd_start_i, in, 1, start a transfer.
- cmd_abort_i, in, 1, abort the current transfer.
- cmd_done_o, out, 1, one-cycle pulse after a transfer completes.
- busy_o, out, 1, high while in RUNNING.
- fifo_elements_o, out, log2(BUFFER_DEPTH)+1, current FIFO occupancy.
- cfg_start_addr_i, in, L2_AWIDTH_NOAL, base byte address.
- cfg_datasize_i, in, 2, beat size: 0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = reserved (increment 0).
- cfg_mode_i, in, 2, addressing mode: 0 LINEAR, 1 2D_ROW, 2 2D_COL, 3 3D.
- cfg_len0_i, in, TRANS_SIZE, inner count minus 1.
- cfg_len1_i, in, TRANS_SIZE, middle count minus 1.
- cfg_len2_i, in, TRANS_SIZE, line stride in bytes.
- cfg_len3_i, in, TRANS_SIZE, plane count minus 1.
- cfg_len4_i, in, TRANS_SIZE, plane stride in bytes.
- stream_data_i, in, DATA_WIDTH, input stream data.
- stream_valid_i, in, 1, input stream valid.
- stream_ready_o, out, 1, input stream ready.

Function
REQ-006 The stream shall enter a BUFFER_DEPTH-entry FIFO: stream_ready_o = not full; push on valid&ready; simultaneous push and pop when full or empty shall be legal and lossless.
REQ-007 rx_ch_valid_o shall equal (FIFO not empty) AND RUNNING; FIFO pop only on rx_ch_valid_o&rx_ch_ready_i (a "beat"); in IDLE data stays buffered, nothing is emitted.
REQ-008 FSM states IDLE and RUNNING; IDLE->RUNNING on cmd_start_i with cmd_abort_i low; RUNNING->IDLE on last beat or on cmd_abort_i.
REQ-009 On start, the block shall latch mode, datasize, all len fields and start address (cfg_* may change afterwards); set pointer, line base and plane base to the start address; clear counters w, l, p.
REQ-010 cmd_start_i in RUNNING shall be ignored.
REQ-011 Increment inc = 1/2/4/0 for datasize 0/1/2/3; address arithmetic modulo 2^L2_AWIDTH_NOAL; strides zero-extended.
REQ-012 LINEAR: per beat, w==len0 -> last; else w+1, ptr+inc.
REQ-013 2D_ROW: per beat, w==len0 and l==len1 -> last; w==len0 -> w=0, l+1, line=ptr=line+len2; else w+1, ptr+inc.
REQ-014 2D_COL: per beat, w==len0 and l==len1 -> last; l==len1 -> l=0, w+1, line=ptr=line+inc; else l+1, ptr+len2.
REQ-015 3D: per beat, w==len0, l==len1, p==len3 -> last; w==len0 and l==len1 -> w=l=0, p+1, plane=line=ptr=plane+len4; w==len0 -> w=0, l+1, line=ptr=line+len2; else w+1, ptr+inc.
REQ-016 Total beats per transfer: (len0+1), (len0+1)(len1+1), or (len0+1)(len1+1)(len3+1).
REQ-017 Last beat: state->IDLE and counters cleared at that edge; cmd_done_o high exactly the next cycle for one cycle; busy_o low the same cycle.
REQ-018 rx_ch_addr_o shall be the registered pointer, stable while valid is high and ready is low.
REQ-019 cmd_abort_i in RUNNING: next cycle IDLE, counters cleared, FIFO flushed, no cmd_done_o pulse; a beat handshaking in the abort cycle is still counted as delivered.
REQ-020 cmd_abort_i in IDLE shall flush the FIFO and take priority over a simultaneous cmd_start_i.

Reset
REQ-021 Asynchronous assertion of resetn_i low shall clear the FSM to IDLE, pointer and bases to 0, counters to 0, mode to LINEAR, FIFO to empty.
REQ-022 During reset: rx_ch_valid_o=0, cmd_done_o=0, busy_o=0, stream_ready_o=0 while held in reset (then 1 after release), fifo_elements_o=0, rx_ch_addr_o=0.
REQ-023 Reset mid-transfer shall abandon the transfer with no done pulse.

Verification
REQ-024 LINEAR, addr 0x100, datasize 2, len0=3, ready tied high -> 4 beats at 0x100/0x104/0x108/0x10C; cmd_done_o one cycle after the 4th beat.
REQ-025 2D_ROW, addr 0x0, ds 0, len0=1, len1=2, len2=0x10 -> addresses 0x00, 0x01, 0x10, 0x11, 0x20, 0x21.
REQ-026 2D_COL, addr 0x0, ds 1, len0=1, len1=1, len2=0x8 -> addresses 0x0, 0x8, 0x2, 0xA.
REQ-027 3D, addr 0x0, ds 2, len0=1, len1=1, len2=0x20, len3=1, len4=0x100 -> addresses 0x0, 0x4, 0x20, 0x24, 0x100, 0x104, 0x120, 0x124; done pulse once.
REQ-028 Random rx_ch_ready_i and stream_valid_i, FIFO filled to BUFFER_DEPTH: no loss or duplication, stream_ready_o=0 while full, address held during stalls.
REQ-029 Abort after 2 of 8 beats -> busy_o falls next cycle, FIFO empty, no done pulse; a following start with len0=0 completes normally.
